// File: rtl/branch_predictor_pkg.sv
`default_nettype none
//============================================================================
// Module  : bp_pkg
// Brief   : Shared encodings for the branch predictor and its resolve logic.
// Revision: 1.0
//============================================================================
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } counter_t;

   typedef enum logic [1:0] {
      PS_NT_TAKEN = 2'd0,
      PS_T_NTAKEN = 2'd1,
      PS_CORRECT  = 2'd2,
      PS_IDLE     = 2'd3
   } pred_status_t;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   function automatic pred_status_t classify(input logic predicted_taken,
                                             input logic taken);
      if (!predicted_taken && taken)
         return PS_NT_TAKEN;
      else if (predicted_taken && !taken)
         return PS_T_NTAKEN;
      else
         return PS_CORRECT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
//============================================================================
// Module  : branch_predictor_if
// Brief   : IF/EX stage bundle between the pipeline and the branch predictor.
// Revision: 1.0
//============================================================================
interface branch_predictor_if #(
   parameter int XLEN       = 32,
   parameter int INDEX_BITS = 6,
   parameter int CNT_WIDTH  = 32
);
   logic [XLEN-1:0]       IF_pc;
   logic [1:0]            IF_branch_prediction;
   logic                  IF_predict_taken;
   logic [INDEX_BITS-1:0] IF_index;

   logic                  EX_Branch;
   logic [2:0]            EX_funct3;
   logic [INDEX_BITS-1:0] EX_index;
   logic [1:0]            EX_branch_prediction;
   logic                  zero;
   logic                  sign;
   logic                  overflow;
   logic                  carry;

   logic                  branch_taken;
   logic [1:0]            prediction_status;
   logic                  mispredict;
   logic [CNT_WIDTH-1:0]  branch_count;
   logic [CNT_WIDTH-1:0]  mispredict_count;

   modport master (
      output IF_pc, EX_Branch, EX_funct3, EX_index, EX_branch_prediction,
             zero, sign, overflow, carry,
      input  IF_branch_prediction, IF_predict_taken, IF_index, branch_taken,
             prediction_status, mispredict, branch_count, mispredict_count
   );

   modport slave (
      input  IF_pc, EX_Branch, EX_funct3, EX_index, EX_branch_prediction,
             zero, sign, overflow, carry,
      output IF_branch_prediction, IF_predict_taken, IF_index, branch_taken,
             prediction_status, mispredict, branch_count, mispredict_count
   );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
//============================================================================
// Module  : sat_counter2
// Brief   : Next-state function of a 2-bit saturating branch counter.
// Revision: 1.0
//============================================================================
module sat_counter2
   import bp_pkg::*;
(
   input  logic     taken,
   input  counter_t cur,
   output counter_t next
);

   always_comb begin
      next = cur;
      if (taken && (cur != ST))
         next = counter_t'(cur + 2'd1);
      else if (!taken && (cur != SNT))
         next = counter_t'(cur - 2'd1);
   end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
//============================================================================
// Module  : branch_predictor
// Brief   : Bimodal/gshare 2-bit predictor with EX-stage resolve and counters.
// Revision: 1.0
//============================================================================
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int INDEX_BITS = 6,
   parameter int GHR_BITS   = 6,
   parameter int GSHARE     = 1,
   parameter int CNT_WIDTH  = 32
)(
   input  logic clk,
   input  logic rst_n,
   branch_predictor_if.slave bp
);

   localparam int ENTRIES = 2 ** INDEX_BITS;

   counter_t              r_table [ENTRIES];
   logic [GHR_BITS-1:0]   r_ghr;
   pred_status_t          r_status;
   logic                  r_mispredict;
   logic [CNT_WIDTH-1:0]  r_branch_count;
   logic [CNT_WIDTH-1:0]  r_mispredict_count;

   logic [INDEX_BITS-1:0] w_pc_idx;
   logic [INDEX_BITS-1:0] w_if_index;
   logic [GHR_BITS:0]     w_ghr_shift;
   logic                  w_valid;
   logic                  w_cond;
   logic                  w_taken;
   counter_t              w_cur;
   counter_t              w_next;
   pred_status_t          w_status;
   logic                  w_unused_pc;

   assign w_pc_idx    = bp.IF_pc[INDEX_BITS+1:2];
   assign w_unused_pc = &{1'b0, bp.IF_pc[XLEN-1:INDEX_BITS+2], bp.IF_pc[1:0]};

   generate
      if (GSHARE != 0) begin : g_gshare
         assign w_if_index = w_pc_idx ^ INDEX_BITS'(r_ghr);
      end else begin : g_bimodal
         logic w_unused_ghr;
         assign w_unused_ghr = ^r_ghr;
         assign w_if_index   = w_pc_idx;
      end
   endgenerate

   // 010/011 are not branch encodings: they never train or count.
   always_comb begin
      w_valid = 1'b0;
      w_cond  = 1'b0;
      if (bp.EX_Branch) begin
         case (bp.EX_funct3)
            BEQ:  begin w_valid = 1'b1; w_cond = bp.zero;                  end
            BNE:  begin w_valid = 1'b1; w_cond = ~bp.zero;                 end
            BLT:  begin w_valid = 1'b1; w_cond = bp.sign ^ bp.overflow;    end
            BGE:  begin w_valid = 1'b1; w_cond = ~(bp.sign ^ bp.overflow); end
            BLTU: begin w_valid = 1'b1; w_cond = bp.carry;                 end
            BGEU: begin w_valid = 1'b1; w_cond = ~bp.carry;                end
            default: begin w_valid = 1'b0; w_cond = 1'b0;                  end
         endcase
      end
   end

   assign w_taken     = w_valid & w_cond;
   assign w_status    = classify(bp.EX_branch_prediction[1], w_taken);
   assign w_cur       = r_table[bp.EX_index];
   assign w_ghr_shift = {r_ghr, w_taken};

   sat_counter2 u_sat_counter2 (
      .taken (w_taken),
      .cur   (w_cur),
      .next  (w_next)
   );

   // Forward the EX write so a same-index fetch sees the trained value.
   always_comb begin
      if (w_valid && (bp.EX_index == w_if_index))
         bp.IF_branch_prediction = w_next;
      else
         bp.IF_branch_prediction = r_table[w_if_index];
   end

   assign bp.IF_predict_taken  = bp.IF_branch_prediction[1];
   assign bp.IF_index          = w_if_index;
   assign bp.branch_taken      = w_taken;
   assign bp.prediction_status = r_status;
   assign bp.mispredict        = r_mispredict;
   assign bp.branch_count      = r_branch_count;
   assign bp.mispredict_count  = r_mispredict_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++)
            r_table[i] <= WNT;
      end else if (w_valid) begin
         r_table[bp.EX_index] <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ghr              <= '0;
         r_status           <= PS_IDLE;
         r_mispredict       <= 1'b0;
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else if (w_valid) begin
         r_ghr          <= w_ghr_shift[GHR_BITS-1:0];
         r_status       <= w_status;
         r_mispredict   <= (w_status != PS_CORRECT);
         r_branch_count <= r_branch_count + 1'b1;
         if (w_status != PS_CORRECT)
            r_mispredict_count <= r_mispredict_count + 1'b1;
      end else begin
         r_status     <= PS_IDLE;
         r_mispredict <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
//============================================================================
// Module  : tb_branch_predictor
// Brief   : Bimodal and gshare predictors checked against a table/history model.
// Revision: 1.0
//============================================================================
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = 32'h100;
   logic        br = 1'b0;
   logic [2:0]  f3 = 3'd0;
   logic [5:0]  exi = 6'd0;
   logic [1:0]  pr = 2'd1;
   logic        z = 1'b0, s = 1'b0, o = 1'b0, c = 1'b0;

   int          n_vec = 0;
   int          n_err = 0;

   int          tab [64];
   int          ghr;
   logic [31:0] bcnt, mcnt;
   int          st_exp;
   bit          mis_exp;

   always #5 clk = ~clk;

   branch_predictor_if bus0 ();
   branch_predictor_if bus1 ();

   assign bus0.IF_pc = pc;                 assign bus1.IF_pc = pc;
   assign bus0.EX_Branch = br;             assign bus1.EX_Branch = br;
   assign bus0.EX_funct3 = f3;             assign bus1.EX_funct3 = f3;
   assign bus0.EX_index = exi;             assign bus1.EX_index = exi;
   assign bus0.EX_branch_prediction = pr;  assign bus1.EX_branch_prediction = pr;
   assign bus0.zero = z;                   assign bus1.zero = z;
   assign bus0.sign = s;                   assign bus1.sign = s;
   assign bus0.overflow = o;               assign bus1.overflow = o;
   assign bus0.carry = c;                  assign bus1.carry = c;

   branch_predictor #(.GSHARE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bp(bus0));
   branch_predictor #(.GSHARE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bp(bus1));

   function automatic bit m_taken();
      if (!br) return 1'b0;
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return s != o;
         3'd5: return s == o;
         3'd6: return c;
         3'd7: return !c;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit m_valid();
      return br && (f3 != 3'd2) && (f3 != 3'd3);
   endfunction

   function automatic int m_status();
      bit t = m_taken();
      if (pr < 2 && t) return 0;
      if (pr >= 2 && !t) return 1;
      return 2;
   endfunction

   function automatic int m_train(input int v, input bit t);
      if (t) return (v == 3) ? 3 : v + 1;
      return (v == 0) ? 0 : v - 1;
   endfunction

   function automatic int m_idx(input bit gshare);
      int p = (pc / 4) % 64;
      return gshare ? (p ^ ghr) : p;
   endfunction

   function automatic int m_read(input bit gshare);
      int i = m_idx(gshare);
      if (m_valid() && exi == i) return m_train(tab[i], m_taken());
      return tab[i];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) tab[i] = 1;
      ghr = 0; bcnt = 0; mcnt = 0; st_exp = 3; mis_exp = 0;
   endtask

   task automatic tick();
      bit v, t; int st, nv;
      v = m_valid(); t = m_taken(); st = v ? m_status() : 3;
      nv = m_train(tab[exi], t);
      @(posedge clk);
      if (rst_n) begin
         if (v) begin
            tab[exi] = nv;
            ghr  = ((ghr * 2) + int'(t)) % 64;
            bcnt = bcnt + 1;
            if (st < 2) mcnt = mcnt + 1;
         end
         st_exp = st;
         mis_exp = (st < 2);
      end
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0; pc = 32'h100; br = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (bus0.IF_branch_prediction !== 2'b01) begin n_err++; $display("FAIL reset_pred got %0d exp 1", bus0.IF_branch_prediction); end
      n_vec++; if (bus0.IF_predict_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %0d exp 0", bus0.IF_predict_taken); end
      n_vec++; if (bus0.prediction_status !== 2'd3) begin n_err++; $display("FAIL reset_status got %0d exp 3", bus0.prediction_status); end
      n_vec++; if (bus0.mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict got %0d exp 0", bus0.mispredict); end
      n_vec++; if (bus0.branch_count !== 32'd0 || bus0.mispredict_count !== 32'd0) begin n_err++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus0.branch_count, bus0.mispredict_count); end
      n_vec++; if (bus1.IF_index !== 6'd0) begin n_err++; $display("FAIL reset_gshare_index got %0d exp 0", bus1.IF_index); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_bimodal_train();
      pc = 32'h100; br = 1'b1; f3 = 3'd0; z = 1'b1; exi = 6'd0; pr = 2'b01;
      #1;
      n_vec++; if (bus0.branch_taken !== 1'b1) begin n_err++; $display("FAIL beq_taken got %0d exp 1", bus0.branch_taken); end
      tick();
      n_vec++; if (bus0.prediction_status !== 2'd0 || bus0.mispredict !== 1'b1) begin n_err++; $display("FAIL beq_status got %0d/%0d exp 0/1", bus0.prediction_status, bus0.mispredict); end
      n_vec++; if (bus0.branch_count !== 32'd1 || bus0.mispredict_count !== 32'd1) begin n_err++; $display("FAIL beq_counts got %0d/%0d exp 1/1", bus0.branch_count, bus0.mispredict_count); end
      br = 1'b0; #1;
      n_vec++; if (bus0.IF_branch_prediction !== 2'b10) begin n_err++; $display("FAIL beq_entry got %0d exp 2", bus0.IF_branch_prediction); end
      n_vec++; if (bus0.IF_predict_taken !== 1'b1) begin n_err++; $display("FAIL beq_predict_taken got %0d exp 1", bus0.IF_predict_taken); end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 4; k++) begin
         br = 1'b1; f3 = 3'd0; z = 1'b1; exi = 6'd0; pr = 2'(tab[0]);
         tick();
         n_vec++; if (bus0.prediction_status !== 2'd2 || bus0.mispredict !== 1'b0) begin n_err++; $display("FAIL sat_status[%0d] got %0d/%0d exp 2/0", k, bus0.prediction_status, bus0.mispredict); end
      end
      br = 1'b0; pc = 32'h100; #1;
      n_vec++; if (bus0.IF_branch_prediction !== 2'b11) begin n_err++; $display("FAIL sat_entry got %0d exp 3", bus0.IF_branch_prediction); end
      n_vec++; if (bus0.branch_count !== 32'd5 || bus0.mispredict_count !== 32'd1) begin n_err++; $display("FAIL sat_counts got %0d/%0d exp 5/1", bus0.branch_count, bus0.mispredict_count); end
   endtask

   task automatic test_blt_not_taken();
      br = 1'b1; f3 = 3'd4; s = 1'b1; o = 1'b1; exi = 6'd0; pr = 2'b11;
      #1;
      n_vec++; if (bus0.branch_taken !== 1'b0) begin n_err++; $display("FAIL blt_taken got %0d exp 0", bus0.branch_taken); end
      tick();
      n_vec++; if (bus0.prediction_status !== 2'd1 || bus0.mispredict !== 1'b1) begin n_err++; $display("FAIL blt_status got %0d/%0d exp 1/1", bus0.prediction_status, bus0.mispredict); end
      br = 1'b0; #1;
      n_vec++; if (bus0.IF_branch_prediction !== 2'b10) begin n_err++; $display("FAIL blt_entry got %0d exp 2", bus0.IF_branch_prediction); end
      n_vec++; if (bus0.prediction_status !== 2'd1) begin n_err++; $display("FAIL blt_status_hold got %0d exp 1", bus0.prediction_status); end
      tick();
      n_vec++; if (bus0.prediction_status !== 2'd3 || bus0.mispredict !== 1'b0) begin n_err++; $display("FAIL idle_status got %0d/%0d exp 3/0", bus0.prediction_status, bus0.mispredict); end
   endtask

   task automatic test_gshare_index();
      @(negedge clk); rst_n = 1'b0; model_reset(); #1;
      @(negedge clk); rst_n = 1'b1;
      br = 1'b1; f3 = 3'd0; exi = 6'd10; pr = 2'b01;
      z = 1'b1; tick();
      z = 1'b1; tick();
      z = 1'b0; tick();
      br = 1'b0; pc = 32'h100; #1;
      n_vec++; if (bus1.IF_index !== 6'd6) begin n_err++; $display("FAIL gshare_index got %0d exp 6", bus1.IF_index); end
      n_vec++; if (bus0.IF_index !== 6'd0) begin n_err++; $display("FAIL bimodal_index got %0d exp 0", bus0.IF_index); end
   endtask

   task automatic test_bypass();
      pc = 32'h14; br = 1'b1; f3 = 3'd0; z = 1'b1; exi = 6'd5; pr = 2'b01;
      #1;
      n_vec++; if (bus0.IF_branch_prediction !== 2'b10) begin n_err++; $display("FAIL bypass_pred got %0d exp 2", bus0.IF_branch_prediction); end
      n_vec++; if (bus1.IF_index !== 6'd3) begin n_err++; $display("FAIL indep_index got %0d exp 3", bus1.IF_index); end
      n_vec++; if (bus1.IF_branch_prediction !== 2'b01) begin n_err++; $display("FAIL indep_pred got %0d exp 1", bus1.IF_branch_prediction); end
      tick();
      br = 1'b0; #1;
      n_vec++; if (bus0.IF_branch_prediction !== 2'b10) begin n_err++; $display("FAIL bypass_written got %0d exp 2", bus0.IF_branch_prediction); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         pc  = $urandom;
         br  = ($urandom_range(0, 3) != 0);
         f3  = 3'($urandom_range(0, 7));
         pr  = 2'($urandom_range(0, 3));
         {z, s, o, c} = 4'($urandom);
         exi = ($urandom_range(0, 1) != 0) ? 6'(m_idx(n % 2 == 1)) : 6'($urandom_range(0, 63));
         #1;
         n_vec++; if (bus0.branch_taken !== m_taken()) begin n_err++; $display("FAIL rnd_taken[%0d] got %0d exp %0d", n, bus0.branch_taken, m_taken()); end
         n_vec++; if (bus0.IF_index !== 6'(m_idx(0))) begin n_err++; $display("FAIL rnd_idx0[%0d] got %0d exp %0d", n, bus0.IF_index, m_idx(0)); end
         n_vec++; if (bus1.IF_index !== 6'(m_idx(1))) begin n_err++; $display("FAIL rnd_idx1[%0d] got %0d exp %0d", n, bus1.IF_index, m_idx(1)); end
         n_vec++; if (bus0.IF_branch_prediction !== 2'(m_read(0))) begin n_err++; $display("FAIL rnd_pred0[%0d] got %0d exp %0d", n, bus0.IF_branch_prediction, m_read(0)); end
         n_vec++; if (bus1.IF_branch_prediction !== 2'(m_read(1))) begin n_err++; $display("FAIL rnd_pred1[%0d] got %0d exp %0d", n, bus1.IF_branch_prediction, m_read(1)); end
         n_vec++; if (bus1.IF_predict_taken !== (m_read(1) >= 2)) begin n_err++; $display("FAIL rnd_ptaken1[%0d] got %0d exp %0d", n, bus1.IF_predict_taken, m_read(1) >= 2); end
         tick();
         n_vec++; if (bus1.prediction_status !== 2'(st_exp)) begin n_err++; $display("FAIL rnd_status[%0d] got %0d exp %0d", n, bus1.prediction_status, st_exp); end
         n_vec++; if (bus1.mispredict !== mis_exp) begin n_err++; $display("FAIL rnd_mispredict[%0d] got %0d exp %0d", n, bus1.mispredict, mis_exp); end
         n_vec++; if (bus0.branch_count !== bcnt || bus1.mispredict_count !== mcnt) begin n_err++; $display("FAIL rnd_counts[%0d] got %0d/%0d exp %0d/%0d", n, bus0.branch_count, bus1.mispredict_count, bcnt, mcnt); end
      end
   endtask

   task automatic test_reset_mid();
      br = 1'b1; f3 = 3'd0; z = 1'b1; exi = 6'd7; pr = 2'b01;
      @(negedge clk); rst_n = 1'b0; model_reset(); #1;
      n_vec++; if (bus0.branch_count !== 32'd0 || bus1.mispredict_count !== 32'd0) begin n_err++; $display("FAIL midrst_counts got %0d/%0d exp 0/0", bus0.branch_count, bus1.mispredict_count); end
      n_vec++; if (bus1.prediction_status !== 2'd3 || bus1.mispredict !== 1'b0) begin n_err++; $display("FAIL midrst_status got %0d/%0d exp 3/0", bus1.prediction_status, bus1.mispredict); end
      @(posedge clk); #1;
      br = 1'b0;
      for (int i = 0; i < 64; i++) begin
         pc = 32'(i * 4); #1;
         n_vec++; if (bus0.IF_branch_prediction !== 2'b01) begin n_err++; $display("FAIL midrst_entry[%0d] got %0d exp 1", i, bus0.IF_branch_prediction); end
      end
      pc = 32'h100; #1;
      n_vec++; if (bus1.IF_index !== 6'd0) begin n_err++; $display("FAIL midrst_ghr got %0d exp 0", bus1.IF_index); end
      @(negedge clk); rst_n = 1'b1;
      br = 1'b1; f3 = 3'd1; z = 1'b0; exi = 6'd0; pr = 2'b01;
      tick();
      n_vec++; if (bus0.prediction_status !== 2'd0 || bus0.branch_count !== 32'd1) begin n_err++; $display("FAIL postrst_branch got %0d/%0d exp 0/1", bus0.prediction_status, bus0.branch_count); end
      br = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bimodal_train();
      test_saturate();
      test_blt_not_taken();
      test_gshare_index();
      test_bypass();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor with resolution unit. It is the successor to the single-branch resolve/compare logic.
- IF stage: indexes a table of 2-bit saturating counters (bimodal, or gshare with a global history register) and returns a prediction.
- EX stage: resolves the branch condition, classifies the prediction, and trains the counter and history.
- Also keeps branch and mispredict performance counters for the CSR file.

Parameters:
- XLEN, 32, PC and operand-flag context width.
- INDEX_BITS, 6, log2 of counter-table entries (64 entries).
- GHR_BITS, 6, global history length; must be <= INDEX_BITS.
- GSHARE, 1, 1 = index is PC-index XOR GHR; 0 = bimodal (PC index only).
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- IF_pc  in  XLEN  fetch PC.
- IF_branch_prediction  out  2  counter value at the computed index (combinational).
- IF_predict_taken  out  1  IF_branch_prediction[1].
- IF_index  out  INDEX_BITS  table index used; carried down the pipe with the instruction.
- EX_Branch  in  1  EX instruction is a conditional branch.
- EX_funct3  in  3  branch type.
- EX_index  in  INDEX_BITS  index carried from IF.
- EX_branch_prediction  in  2  counter value carried from IF.
- zero, sign, overflow, carry  in  1 each  ALU flags of rs1-rs2.
- branch_taken  out  1  resolved outcome (combinational).
- prediction_status  out  2  registered: 0 = predicted not-taken/was taken; 1 = predicted taken/not taken; 2 = correct; 3 = idle.
- mispredict  out  1  registered; high when prediction_status is 0 or 1.
- branch_count  out  CNT_WIDTH  resolved branches.
- mispredict_count  out  CNT_WIDTH  mispredictions.

Behaviour:
- Reset (async, rst_n low):
  - All table entries = 2'b01 (weakly not taken); GHR = 0.
  - prediction_status = 3; mispredict = 0; both counters = 0.
  - Reset mid-update discards the update.
- Index:
  - pc_idx = IF_pc[INDEX_BITS+1:2].
  - If GSHARE: IF_index = pc_idx XOR zero-extended GHR; else IF_index = pc_idx.
- Read: asynchronous, zero latency.
  - Same-cycle write to the same index is bypassed: IF_branch_prediction shows the post-update value.
- Resolve (combinational, only when EX_Branch = 1; otherwise branch_taken = 0):
  - 000 zero; 001 ~zero; 100 sign^overflow; 101 ~(sign^overflow); 110 carry; 111 ~carry.
  - 010/011: branch_taken = 0 and the branch is treated as not valid: no update, no count, status = 3.
- Classify: predicted-taken = EX_branch_prediction[1].
  - Status = 0 if not-taken predicted and taken.
  - Status = 1 if taken predicted and not taken.
  - Status = 2 otherwise.
- Registered on the next rising edge after a valid EX branch:
  - prediction_status, mispredict updated; 1-cycle latency.
  - Cycle without a valid branch: status returns to 3, mispredict = 0.
- Training on a valid branch (read-modify-write of the live entry at EX_index, not the carried value):
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
- GHR: non-speculative; on each valid branch, GHR <= {GHR[GHR_BITS-2:0], branch_taken}.
- Counters:
  - branch_count +1 per valid branch.
  - mispredict_count +1 when status would be 0 or 1.
  - Both wrap modulo 2^CNT_WIDTH.
- Simultaneous IF read and EX write to different indices are independent.

Decomposition:
- Shared package bp_pkg:
  - Counter encodings SNT = 00, WNT = 01, WT = 10, ST = 11.
  - Status encodings PS_NT_TAKEN = 0, PS_T_NTAKEN = 1, PS_CORRECT = 2, PS_IDLE = 3.
  - funct3 branch constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
- One sub-module, sat_counter2: 2-bit saturating next-state function (taken in, cur in, next out), instantiated in the update path.

Test Plan:
- Reset then IF_pc = 0x100 -> IF_branch_prediction = 01, IF_predict_taken = 0, counters 0, prediction_status = 3.
- GSHARE = 0, BEQ taken (zero = 1) at index 0 with carried 01 ->
  - Next cycle prediction_status = 0, mispredict = 1.
  - Entry 0 = 10; branch_count = 1, mispredict_count = 1.
- Three further taken BEQ at index 0 ->
  - Entry saturates at 11; a fourth update keeps it at 11.
  - Statuses 2,2,2 once the carried value is >= 10.
- BLT with sign = 1, overflow = 1 (not taken), carried 11 -> status 1; entry 11 -> 10.
- GSHARE = 1: resolve taken, taken, not-taken -> GHR = 000110; IF_pc = 0x100 (pc_idx = 0) -> IF_index = 6.
- Same-cycle EX update and IF read at index 5 (entry 01, taken) -> IF_branch_prediction = 10 that cycle.
- Assert rst_n mid-stream -> table, GHR and counters cleared immediately, no pending update applied.
